// File: rtl/alu_op_issuer.sv
// Purpose : issue stage for the 32-bit ALU; decodes opcode/funct, registers operands and control, captures the result.
// Latency : accept at edge k, alu_* valid after edge k, res_valid after edge k+1; one op per 3 cycles at best.
// Backpress: in_ready is low from accept until the result is taken; res_data/res_zero hold while res_ready is low.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            request handshake; alu_op, funct, opa, opb are request payload
//   alu_a, alu_b, alu_ctrl       registered operands and control to the combinational ALU
//   alu_out, alu_zero            ALU result and zero flag
//   res_valid/res_ready          result handshake; res_data, res_zero are result payload
//   illegal                      only when ALU_ISSUE_ILLEGAL_EN is defined: unrecognised R-type funct
//
// Build option: define ALU_ISSUE_ILLEGAL_EN to flag unrecognised R-type funct values and force
// a zero result for them; otherwise they decode to add.
module alu_op_issuer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
`ifdef ALU_ISSUE_ILLEGAL_EN
  output logic             illegal,
`endif
  output logic             res_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_SUB = 3'b110;
  localparam logic [2:0] CTRL_SLT = 3'b111;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_zero_q, res_zero_d;
  logic             res_valid_q, res_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [2:0]       dec_ctrl;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic             illegal_q, illegal_d;
  logic             dec_illegal;
`endif

  // Opcode / funct decode to the ALU control code.
  always_comb begin
    dec_ctrl = CTRL_ADD;
`ifdef ALU_ISSUE_ILLEGAL_EN
    dec_illegal = 1'b0;
`endif
    case (alu_op)
      2'b00: dec_ctrl = CTRL_ADD;
      2'b01: dec_ctrl = CTRL_SUB;
      2'b11: dec_ctrl = CTRL_OR;
      default: begin
        case (funct)
          6'b100000: dec_ctrl = CTRL_ADD;
          6'b100010: dec_ctrl = CTRL_SUB;
          6'b100100: dec_ctrl = CTRL_AND;
          6'b100101: dec_ctrl = CTRL_OR;
          6'b101010: dec_ctrl = CTRL_SLT;
          default: begin
`ifdef ALU_ISSUE_ILLEGAL_EN
            dec_ctrl    = CTRL_AND;
            dec_illegal = 1'b1;
`else
            dec_ctrl    = CTRL_ADD;
`endif
          end
        endcase
      end
    endcase
  end

  // Next-state logic. in_ready/res_valid are registered so they depend on state only.
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_valid_d = res_valid_q;
    in_ready_d  = in_ready_q;
`ifdef ALU_ISSUE_ILLEGAL_EN
    illegal_d   = illegal_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          alu_a_d    = opa;
          alu_b_d    = opb;
          alu_ctrl_d = dec_ctrl;
`ifdef ALU_ISSUE_ILLEGAL_EN
          illegal_d  = dec_illegal;
`endif
          in_ready_d = 1'b0;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        // ALU inputs have been stable for a full cycle; sample its output.
        res_data_d  = alu_out;
        res_zero_d  = alu_zero;
`ifdef ALU_ISSUE_ILLEGAL_EN
        if (illegal_q) begin
          res_data_d = '0;
          res_zero_d = 1'b1;
        end
`endif
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        // A request arriving here is only seen once back in IDLE.
        if (res_ready) begin
          res_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= CTRL_AND;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef ALU_ISSUE_ILLEGAL_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_valid_q <= res_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef ALU_ISSUE_ILLEGAL_EN
      illegal_q   <= illegal_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
`ifdef ALU_ISSUE_ILLEGAL_EN
  assign illegal   = illegal_q;
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// Purpose : directed bench for alu_op_issuer with a behavioural ALU and a result scoreboard.
// Latency : expects alu_* one edge after accept and res_valid one edge later.
// Backpress: exercises held results with res_ready low and a request waiting during DONE.
module tb_alu_op_issuer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] opa, opb;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_zero;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic        illegal;
`endif

  int checks = 0;
  int errors = 0;

  // Expected {res_zero, res_data} pushed at accept, popped when the result appears.
  logic [32:0] sb_q[$];

  always #5 clk = ~clk;

  alu_op_issuer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .opa(opa), .opb(opb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data),
`ifdef ALU_ISSUE_ILLEGAL_EN
    .illegal(illegal),
`endif
    .res_zero(res_zero)
  );

  // Behavioural ALU.
  always_comb begin
    alu_out = 32'h0;
    case (alu_ctrl)
      3'b000: alu_out = alu_a & alu_b;
      3'b001: alu_out = alu_a | alu_b;
      3'b010: alu_out = alu_a + alu_b;
      3'b110: alu_out = alu_a - alu_b;
      3'b111: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_out = 32'h0;
    endcase
    alu_zero = (alu_out == 32'h0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    funct    = fn;
    opa      = a;
    opb      = b;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'd0);
    chk({tag, "_res_data"}, res_data, 32'd0);
    chk({tag, "_res_zero"}, 32'(res_zero), 32'd0);
  endtask

  // Bounded wait for res_valid; returns the number of edges waited.
  task automatic wait_result(input string tag, output int n);
    n = 1;
    step();
    while (!res_valid && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd1);
  endtask

  task automatic pop_check(input string tag);
    logic [32:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_data"}, res_data, e[31:0]);
      chk({tag, "_zero"}, 32'(res_zero), 32'(e[32]));
    end
  endtask

  // Full transaction from IDLE with res_ready high.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [2:0] exp_ctrl,
                       input logic [31:0] exp_data, input logic exp_zero);
    int n;
    chk({tag, "_rdy_before"}, 32'(in_ready), 32'd1);
    drive_req(op, fn, a, b);
    res_ready = 1'b1;
    step();
    in_valid = 1'b0;
    sb_q.push_back({exp_zero, exp_data});
    chk({tag, "_ctrl"}, 32'(alu_ctrl), 32'(exp_ctrl));
    chk({tag, "_alu_a"}, alu_a, a);
    chk({tag, "_alu_b"}, alu_b, b);
    chk({tag, "_rdy_exec"}, 32'(in_ready), 32'd0);
    chk({tag, "_vld_exec"}, 32'(res_valid), 32'd0);
    wait_result(tag, n);
    pop_check(tag);
    step();
    chk({tag, "_vld_after"}, 32'(res_valid), 32'd0);
    chk({tag, "_rdy_after"}, 32'(in_ready), 32'd1);
    chk({tag, "_ctrl_hold"}, 32'(alu_ctrl), 32'(exp_ctrl));
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_op    = 2'b00;
    funct     = 6'b0;
    opa       = 32'h0;
    opb       = 32'h0;
    res_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    step();
    rst_n = 1'b1;
    step();
    check_reset_outputs("post_reset");

    // Directed operations.
    do_op("add",     2'b00, 6'b000000, 32'd5, 32'd7, 3'b010, 32'd12, 1'b0);
    do_op("sub_op",  2'b01, 6'b000000, 32'd20, 32'd3, 3'b110, 32'd17, 1'b0);
    do_op("r_sub_z", 2'b10, 6'b100010, 32'd9, 32'd9, 3'b110, 32'd0, 1'b1);
    do_op("r_add",   2'b10, 6'b100000, 32'h8000_0000, 32'h8000_0000, 3'b010, 32'd0, 1'b1);
    do_op("r_and",   2'b10, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'b000, 32'h00F0_1234, 1'b0);
    do_op("r_or",    2'b10, 6'b100101, 32'hA000_0000, 32'h0000_000A, 3'b001, 32'hA000_000A, 1'b0);
    do_op("slt_neg", 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 3'b111, 32'd1, 1'b0);
    do_op("slt_pos", 2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF, 3'b111, 32'd0, 1'b1);
`ifdef ALU_ISSUE_ILLEGAL_EN
    do_op("illegal", 2'b10, 6'b000000, 32'd3, 32'd4, 3'b000, 32'd0, 1'b1);
    chk("illegal_flag", 32'(illegal), 32'd1);
    do_op("legal_after", 2'b00, 6'b000000, 32'd1, 32'd2, 3'b010, 32'd3, 1'b0);
    chk("illegal_clear", 32'(illegal), 32'd0);
`else
    do_op("illegal", 2'b10, 6'b000000, 32'd3, 32'd4, 3'b010, 32'd7, 1'b0);
`endif

    // Backpressure: or held in DONE with a second request waiting.
    res_ready = 1'b0;
    drive_req(2'b11, 6'b000000, 32'h0000_00F0, 32'h0000_000F);
    step();
    sb_q.push_back({1'b0, 32'h0000_00FF});
    drive_req(2'b00, 6'b000000, 32'd100, 32'd23);
    chk("bp_ctrl", 32'(alu_ctrl), 32'd1);
    wait_result("bp", n);
    pop_check("bp");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold_vld", 32'(res_valid), 32'd1);
      chk("bp_hold_rdy", 32'(in_ready), 32'd0);
      chk("bp_hold_data", res_data, 32'h0000_00FF);
      chk("bp_hold_a", alu_a, 32'h0000_00F0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("bp_idle_vld", 32'(res_valid), 32'd0);
    chk("bp_idle_rdy", 32'(in_ready), 32'd1);
    chk("bp_not_taken", alu_a, 32'h0000_00F0);
    step();
    in_valid = 1'b0;
    sb_q.push_back({1'b0, 32'd123});
    chk("bp_pending_a", alu_a, 32'd100);
    chk("bp_pending_ctrl", 32'(alu_ctrl), 32'd2);
    wait_result("bp2", n);
    pop_check("bp2");
    res_ready = 1'b1;
    step();
    chk("bp2_done_rdy", 32'(in_ready), 32'd1);

    // Reset while in EXEC discards the operation.
    drive_req(2'b00, 6'b000000, 32'd11, 32'd22);
    step();
    in_valid = 1'b0;
    chk("rst_exec_a", alu_a, 32'd11);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_exec");
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_no_result", 32'(res_valid), 32'd0);
      chk("rst_idle_rdy", 32'(in_ready), 32'd1);
    end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_issuer.md
# alu_op_issuer

Sequential front end for the 32-bit datapath ALU. It accepts one operation per handshake: opcode class, funct field and two operands. It decodes these into the ALU's 3-bit control code, drives the operand and control lines into the combinational ALU, and captures the ALU result and zero flag into a registered, handshaked result port. It sits between the multi-cycle control/issue logic and the ALU, and isolates the ALU's combinational path between two register stages.

## Interface
- `WIDTH`, 32, operand and result width (must match the ALU).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept a request.
- `alu_op`  in  2  operation class:
  - 00 = add
  - 01 = sub
  - 10 = R-type (decode from `funct`)
  - 11 = or
- `funct`  in  6  R-type function field.
- `opa`, `opb`  in  WIDTH  operands.
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU.
- `alu_ctrl`  out  3  registered ALU control:
  - 000 = and
  - 001 = or
  - 010 = add
  - 110 = sub
  - 111 = slt
- `alu_out`  in  WIDTH  ALU result.
- `alu_zero`  in  1  ALU zero flag.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  WIDTH  registered result.
- `res_zero`  out  1  registered zero flag.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: `in_ready`=1.
  - On `in_valid`&`in_ready`: latch `opa`→`alu_a`, `opb`→`alu_b`, decoded code→`alu_ctrl`; go to EXEC.
  - Otherwise hold.
- EXEC: the ALU settles combinationally. Capture `alu_out`→`res_data` and `alu_zero`→`res_zero`; go to DONE.
- DONE: `res_valid`=1. `res_data` and `res_zero` stay stable until the cycle where `res_ready`=1, then go to IDLE.
- `in_ready`=0 in EXEC and DONE. Requests presented there are not consumed; the requester must hold them.
- `in_ready` and `res_valid` are decoded from state only. There are no combinational paths from the handshake inputs.
- Decode of `alu_op`=10 by `funct`:
  - 100000 → 010
  - 100010 → 110
  - 100100 → 000
  - 100101 → 001
  - 101010 → 111
  - any other value → see Configuration.
- `alu_a`, `alu_b` and `alu_ctrl` hold their last values after a transaction completes; they do not return to zero.
- slt is signed. Arithmetic is the ALU's; this block does not modify the result.

## Timing
- Reset, asynchronous, values while `rst_n`=0:
  - state = IDLE.
  - `alu_a`, `alu_b`, `res_data` = 0.
  - `alu_ctrl` = 000.
  - `res_zero` = 0.
  - `res_valid` = 0.
  - `in_ready` = 1.
- Accept at edge k. `alu_*` are valid after edge k. `res_valid` rises after edge k+1.
- Latency: 2 cycles from accept to result valid.
- Throughput: at best one operation per 3 cycles (`res_ready` held at 1).
- `res_ready` with `res_valid`=0 is ignored.
- `in_valid` in DONE together with `res_ready`=1: not accepted that cycle. It is accepted in the following IDLE cycle.
- Reset mid-operation (EXEC or DONE): the transaction is discarded, all outputs return to reset values, and no result is presented.

## Configuration
- `ALU_ISSUE_ILLEGAL_EN` not defined (default):
  - Unrecognized R-type `funct` decodes to add (010).
  - No extra port.
- `ALU_ISSUE_ILLEGAL_EN` defined:
  - Adds output `illegal` (1 bit), registered, reset 0. It is set at accept when `alu_op`=10 and `funct` is unrecognized, and it is valid with `res_valid`.
  - For such an operation `alu_ctrl` = 000, and `res_data` is forced to 0 with `res_zero`=1 in EXEC regardless of `alu_out`.
  - `illegal` clears when the next operation is accepted.

## Test plan
- Add: `alu_op`=00, `opa`=5, `opb`=7, `res_ready`=1 → `alu_ctrl`=010. Two cycles after accept: `res_valid`=1, `res_data`=12, `res_zero`=0. One cycle later: `in_ready`=1.
- R-type sub with zero: `alu_op`=10, `funct`=100010, `opa`=`opb`=9 → `alu_ctrl`=110, `res_data`=0, `res_zero`=1.
- Signed slt: `funct`=101010, `opa`=32'hFFFFFFFF, `opb`=1 → `res_data`=1. With the operands swapped → `res_data`=0, `res_zero`=1.
- Backpressure: complete an or (`alu_op`=11, 32'hF0 | 32'h0F) with `res_ready`=0 for 4 cycles → `res_data`=32'hFF stable, `res_valid`=1, `in_ready`=0 throughout, and a new `in_valid` is not consumed. Raise `res_ready` → IDLE next cycle, then the pending request is accepted.
- Illegal funct 000000, `opa`=3, `opb`=4:
  - Without the macro → `res_data`=7.
  - With `ALU_ISSUE_ILLEGAL_EN` → `illegal`=1, `res_data`=0, `res_zero`=1.
- Reset in EXEC: pulse `rst_n` low → `res_valid` never asserts for that operation, all outputs return to reset values, and `in_ready`=1 after release.
